ysyx_22040125_idu_stage: RTL and testbench
==========================================

YSYX_22040125_IDU_STAGE -- requirements
Module: ysyx_22040125_idu_stage

Interface
REQ-001 Parameter XLEN, default 64: datapath width; imm and pc outputs are XLEN bits.
REQ-002 Parameter DEPTH, default 2: decoded-entry queue depth; power of two, 2..8.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1; in_ready  output  1: fetch-side handshake.
REQ-006 in_inst  input  32; in_pc  input  XLEN: instruction word and its pc.
REQ-007 flush  input  1: discards all queued entries (redirect).
REQ-008 out_valid  output  1; out_ready  input  1: execute-side handshake.
REQ-009 out_pc  output  XLEN; out_imm  output  XLEN; out_op  output  12; out_rd/out_rs1/out_rs2  output  5 each.
REQ-010 out_pc_sel  output  3; out_src1_sel/out_src2_sel  output  2 each; out_mem_size  output  2 (0=B,1=H,2=W,3=D); out_mem_unsigned  output  1.
REQ-011 out_data_wen, out_data_ren, out_reg_wen, out_word_op, out_ebreak, out_illegal  output  1 each.

Function
REQ-012 Transfer on a port occurs only in a cycle where valid and ready are both high.
REQ-013 in_ready = !full; no enqueue when full, even with a simultaneous dequeue.
REQ-014 Decode is combinational on in_inst; the decoded bundle is written into the queue at the enqueue edge; latency from accepted input to out_valid is exactly 1 cycle.
REQ-015 out_valid = !empty; out_* reflect the head entry and hold stable while out_valid && !out_ready.
REQ-016 Decoding covers all RV64I base opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, MISC-MEM, SYSTEM.
REQ-017 Immediates are sign-extended to XLEN by type: I, S, B, U, J; R-type gives imm = 0.
REQ-018 out_word_op = 1 for OP-32/OP-IMM-32; for shift-immediates imm[5:0] (RV64) carries shamt.
REQ-019 out_mem_size = funct3[1:0] and out_mem_unsigned = funct3[2] for loads/stores; data_ren = LOAD; data_wen = STORE.
REQ-020 out_reg_wen = 1 for R, I (except FENCE/ECALL/EBREAK), U, J types and 0 otherwise; out_reg_wen is forced to 0 when rd = 0.
REQ-021 pc_sel: 3'b100 JALR, 3'b010 JAL, 3'b011 BRANCH, 3'b001 otherwise.
REQ-022 src1_sel = 2'b01 (pc) for JAL/AUIPC/BRANCH-target, else 2'b10 (rs1); src2_sel = 2'b01 (imm) for I/U/S/J, else 2'b10 (rs2).
REQ-023 EBREAK (32'h00100073): out_ebreak = 1 and out_rs1 = 5'd10.
REQ-024 Any unrecognised opcode/funct3/funct7 combination: out_illegal = 1, out_reg_wen/data_wen/data_ren = 0, out_op = 0.
REQ-025 Pointers wrap modulo DEPTH; the count saturates neither way; simultaneous enqueue and dequeue leave the count unchanged.
REQ-026 flush empties the queue at the next edge and takes priority over a same-cycle enqueue and dequeue; in_ready is unaffected by flush in the flush cycle.

Reset
REQ-027 While rst is high the queue is empty: out_valid = 0 and in_ready = 0; after rst drops, in_ready = 1.
REQ-028 When the queue is empty, all out_* payload outputs are 0.
REQ-029 Reset mid-transfer discards all entries; no partial entry survives.

Configuration
REQ-030 Macro YSYX_22040125_RVM_EN: when defined, MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the *W forms (funct7 = 0000001) decode to dedicated op codes.
REQ-031 When YSYX_22040125_RVM_EN is undefined, the instructions in REQ-030 are flagged out_illegal.

Structure
REQ-032 OP_* codes, pc_sel/src_sel encodings and opcode constants reside in the shared ysyx_22040125_config package/include.
REQ-033 The combinational decoder is a sub-module, ysyx_22040125_idu_dec; the queue and handshake logic live in the top module.

Verification
REQ-034 Reset, then addi x1,x0,-1 (32'hfff00093) -> next cycle out_valid = 1, imm = 64'hffff_ffff_ffff_ffff, op = OP_ADD, reg_wen = 1.
REQ-035 Hold out_ready = 0 and push DEPTH instructions -> in_ready = 0; the head is stable; one pop -> in_ready = 1 the next cycle.
REQ-036 Push 32'h00100073 -> out_ebreak = 1 and out_rs1 = 10.
REQ-037 Push 32'hffffffff -> out_illegal = 1 and all enables 0.
REQ-038 Queue full plus flush with in_valid = 1 -> empty next cycle, out_valid = 0, and the new input is dropped.
REQ-039 mul x3,x1,x2 (32'h022081b3): with the macro defined -> OP_MUL; without it -> out_illegal = 1.

Source files
------------

// File: rtl/ysyx_22040125_config.sv
// rtl/ysyx_22040125_config.sv - shared opcode constants, op codes, select encodings and decoded-bundle type
package ysyx_22040125_config;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INST_ECALL  = 32'h00000073;
   localparam logic [31:0] INST_EBREAK = 32'h00100073;

   localparam logic [2:0] PC_SEL_SEQ  = 3'b001;
   localparam logic [2:0] PC_SEL_JAL  = 3'b010;
   localparam logic [2:0] PC_SEL_BR   = 3'b011;
   localparam logic [2:0] PC_SEL_JALR = 3'b100;

   localparam logic [1:0] SRC_PC  = 2'b01;
   localparam logic [1:0] SRC_IMM = 2'b01;
   localparam logic [1:0] SRC_REG = 2'b10;

   // Loads, stores and M-extension codes are laid out so that op = base + funct3
   localparam logic [11:0] OP_NONE  = 12'd0,  OP_ADD   = 12'd1,  OP_SUB   = 12'd2,  OP_SLL    = 12'd3;
   localparam logic [11:0] OP_SLT   = 12'd4,  OP_SLTU  = 12'd5,  OP_XOR   = 12'd6,  OP_SRL    = 12'd7;
   localparam logic [11:0] OP_SRA   = 12'd8,  OP_OR    = 12'd9,  OP_AND   = 12'd10, OP_LUI    = 12'd11;
   localparam logic [11:0] OP_AUIPC = 12'd12, OP_JAL   = 12'd13, OP_JALR  = 12'd14, OP_BEQ    = 12'd15;
   localparam logic [11:0] OP_BNE   = 12'd16, OP_BLT   = 12'd17, OP_BGE   = 12'd18, OP_BLTU   = 12'd19;
   localparam logic [11:0] OP_BGEU  = 12'd20, OP_LB    = 12'd21, OP_LH    = 12'd22, OP_LW     = 12'd23;
   localparam logic [11:0] OP_LD    = 12'd24, OP_LBU   = 12'd25, OP_LHU   = 12'd26, OP_LWU    = 12'd27;
   localparam logic [11:0] OP_SB    = 12'd28, OP_SH    = 12'd29, OP_SW    = 12'd30, OP_SD     = 12'd31;
   localparam logic [11:0] OP_ADDW  = 12'd32, OP_SUBW  = 12'd33, OP_SLLW  = 12'd34, OP_SRLW   = 12'd35;
   localparam logic [11:0] OP_SRAW  = 12'd36, OP_FENCE = 12'd37, OP_ECALL = 12'd38, OP_EBREAK = 12'd39;
   localparam logic [11:0] OP_MUL   = 12'd40, OP_MULH  = 12'd41, OP_MULHSU = 12'd42, OP_MULHU = 12'd43;
   localparam logic [11:0] OP_DIV   = 12'd44, OP_DIVU  = 12'd45, OP_REM   = 12'd46, OP_REMU   = 12'd47;
   localparam logic [11:0] OP_MULW  = 12'd48, OP_DIVW  = 12'd49, OP_DIVUW = 12'd50, OP_REMW   = 12'd51;
   localparam logic [11:0] OP_REMUW = 12'd52;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
   } imm_fmt_e;

   typedef struct packed {
      logic [11:0] op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  pc_sel;
      logic [1:0]  src1_sel;
      logic [1:0]  src2_sel;
      logic [1:0]  mem_size;
      logic        mem_unsigned;
      logic        data_wen;
      logic        data_ren;
      logic        reg_wen;
      logic        word_op;
      logic        ebreak;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/ysyx_22040125_idu_stage_if.sv
// rtl/ysyx_22040125_idu_stage_if.sv - fetch-side and execute-side handshake bundle of the IDU stage
interface ysyx_22040125_idu_stage_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [11:0]     out_op;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_pc_sel;
   logic [1:0]      out_src1_sel;
   logic [1:0]      out_src2_sel;
   logic [1:0]      out_mem_size;
   logic            out_mem_unsigned;
   logic            out_data_wen;
   logic            out_data_ren;
   logic            out_reg_wen;
   logic            out_word_op;
   logic            out_ebreak;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_op, out_rd, out_rs1, out_rs2,
             out_pc_sel, out_src1_sel, out_src2_sel, out_mem_size, out_mem_unsigned,
             out_data_wen, out_data_ren, out_reg_wen, out_word_op, out_ebreak, out_illegal
   );

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_op, out_rd, out_rs1, out_rs2,
             out_pc_sel, out_src1_sel, out_src2_sel, out_mem_size, out_mem_unsigned,
             out_data_wen, out_data_ren, out_reg_wen, out_word_op, out_ebreak, out_illegal
   );
endinterface

// File: rtl/ysyx_22040125_idu_dec.sv
// rtl/ysyx_22040125_idu_dec.sv - combinational RV64I decoder; YSYX_22040125_RVM_EN adds the M-extension op codes
module ysyx_22040125_idu_dec
   import ysyx_22040125_config::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     inst,
   output dec_t            ctl,
   output logic [XLEN-1:0] imm
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   imm_fmt_e   fmt;
   logic       legal;

   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];

   always_comb begin
      ctl          = '0;
      ctl.rd       = inst[11:7];
      ctl.rs1      = inst[19:15];
      ctl.rs2      = inst[24:20];
      ctl.pc_sel   = PC_SEL_SEQ;
      ctl.src1_sel = SRC_REG;
      ctl.src2_sel = SRC_REG;
      fmt          = IMM_NONE;
      legal        = 1'b1;

      case (opcode)
         OPC_LUI: begin
            ctl.op = OP_LUI; fmt = IMM_U; ctl.src2_sel = SRC_IMM; ctl.reg_wen = 1'b1;
         end
         OPC_AUIPC: begin
            ctl.op = OP_AUIPC; fmt = IMM_U; ctl.reg_wen = 1'b1;
            ctl.src1_sel = SRC_PC; ctl.src2_sel = SRC_IMM;
         end
         OPC_JAL: begin
            ctl.op = OP_JAL; fmt = IMM_J; ctl.reg_wen = 1'b1; ctl.pc_sel = PC_SEL_JAL;
            ctl.src1_sel = SRC_PC; ctl.src2_sel = SRC_IMM;
         end
         OPC_JALR: begin
            legal = (f3 == 3'b000);
            ctl.op = OP_JALR; fmt = IMM_I; ctl.reg_wen = 1'b1; ctl.pc_sel = PC_SEL_JALR;
            ctl.src2_sel = SRC_IMM;
         end
         OPC_BRANCH: begin
            fmt = IMM_B; ctl.pc_sel = PC_SEL_BR; ctl.src1_sel = SRC_PC;
            case (f3)
               3'b000:  ctl.op = OP_BEQ;
               3'b001:  ctl.op = OP_BNE;
               3'b100:  ctl.op = OP_BLT;
               3'b101:  ctl.op = OP_BGE;
               3'b110:  ctl.op = OP_BLTU;
               3'b111:  ctl.op = OP_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            legal = (f3 != 3'b111);
            ctl.op = OP_LB + {9'b0, f3}; fmt = IMM_I; ctl.src2_sel = SRC_IMM;
            ctl.data_ren = 1'b1; ctl.reg_wen = 1'b1;
            ctl.mem_size = f3[1:0]; ctl.mem_unsigned = f3[2];
         end
         OPC_STORE: begin
            legal = !f3[2];
            ctl.op = OP_SB + {9'b0, f3}; fmt = IMM_S; ctl.src2_sel = SRC_IMM;
            ctl.data_wen = 1'b1;
            ctl.mem_size = f3[1:0]; ctl.mem_unsigned = f3[2];
         end
         OPC_OP_IMM: begin
            fmt = IMM_I; ctl.src2_sel = SRC_IMM; ctl.reg_wen = 1'b1;
            case (f3)
               3'b000: ctl.op = OP_ADD;
               3'b010: ctl.op = OP_SLT;
               3'b011: ctl.op = OP_SLTU;
               3'b100: ctl.op = OP_XOR;
               3'b110: ctl.op = OP_OR;
               3'b111: ctl.op = OP_AND;
               3'b001: begin
                  fmt = IMM_SH; ctl.op = OP_SLL; legal = (inst[31:26] == 6'b000000);
               end
               default: begin
                  fmt = IMM_SH;
                  if (inst[31:26] == 6'b000000)      ctl.op = OP_SRL;
                  else if (inst[31:26] == 6'b010000) ctl.op = OP_SRA;
                  else                               legal = 1'b0;
               end
            endcase
         end
         OPC_OP_IMM32: begin
            fmt = IMM_I; ctl.src2_sel = SRC_IMM; ctl.reg_wen = 1'b1; ctl.word_op = 1'b1;
            case (f3)
               3'b000: ctl.op = OP_ADDW;
               3'b001: begin
                  fmt = IMM_SH; ctl.op = OP_SLLW; legal = (f7 == 7'b0000000);
               end
               3'b101: begin
                  fmt = IMM_SH;
                  if (f7 == 7'b0000000)      ctl.op = OP_SRLW;
                  else if (f7 == 7'b0100000) ctl.op = OP_SRAW;
                  else                       legal = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP: begin
            ctl.reg_wen = 1'b1;
            case (f7)
               7'b0000000: begin
                  case (f3)
                     3'b000:  ctl.op = OP_ADD;
                     3'b001:  ctl.op = OP_SLL;
                     3'b010:  ctl.op = OP_SLT;
                     3'b011:  ctl.op = OP_SLTU;
                     3'b100:  ctl.op = OP_XOR;
                     3'b101:  ctl.op = OP_SRL;
                     3'b110:  ctl.op = OP_OR;
                     default: ctl.op = OP_AND;
                  endcase
               end
               7'b0100000: begin
                  if (f3 == 3'b000)      ctl.op = OP_SUB;
                  else if (f3 == 3'b101) ctl.op = OP_SRA;
                  else                   legal = 1'b0;
               end
               7'b0000001: begin
`ifdef YSYX_22040125_RVM_EN
                  ctl.op = OP_MUL + {9'b0, f3};
`else
                  legal = 1'b0;
`endif
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP32: begin
            ctl.reg_wen = 1'b1; ctl.word_op = 1'b1;
            case (f7)
               7'b0000000: begin
                  if (f3 == 3'b000)      ctl.op = OP_ADDW;
                  else if (f3 == 3'b001) ctl.op = OP_SLLW;
                  else if (f3 == 3'b101) ctl.op = OP_SRLW;
                  else                   legal = 1'b0;
               end
               7'b0100000: begin
                  if (f3 == 3'b000)      ctl.op = OP_SUBW;
                  else if (f3 == 3'b101) ctl.op = OP_SRAW;
                  else                   legal = 1'b0;
               end
               7'b0000001: begin
`ifdef YSYX_22040125_RVM_EN
                  case (f3)
                     3'b000:  ctl.op = OP_MULW;
                     3'b100:  ctl.op = OP_DIVW;
                     3'b101:  ctl.op = OP_DIVUW;
                     3'b110:  ctl.op = OP_REMW;
                     3'b111:  ctl.op = OP_REMUW;
                     default: legal = 1'b0;
                  endcase
`else
                  legal = 1'b0;
`endif
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_MISC_MEM: begin
            legal = (f3 == 3'b000);
            ctl.op = OP_FENCE; fmt = IMM_I; ctl.src2_sel = SRC_IMM;
         end
         OPC_SYSTEM: begin
            fmt = IMM_I; ctl.src2_sel = SRC_IMM;
            if (inst == INST_ECALL) begin
               ctl.op = OP_ECALL;
            end else if (inst == INST_EBREAK) begin
               ctl.op = OP_EBREAK; ctl.ebreak = 1'b1; ctl.rs1 = 5'd10;
            end else begin
               legal = 1'b0;
            end
         end
         default: legal = 1'b0;
      endcase

      // An illegal word keeps only its raw register fields and the sequential defaults
      if (!legal) begin
         ctl          = '0;
         ctl.rd       = inst[11:7];
         ctl.rs1      = inst[19:15];
         ctl.rs2      = inst[24:20];
         ctl.pc_sel   = PC_SEL_SEQ;
         ctl.src1_sel = SRC_REG;
         ctl.src2_sel = SRC_REG;
         ctl.illegal  = 1'b1;
         fmt          = IMM_NONE;
      end

      if (ctl.rd == 5'd0) ctl.reg_wen = 1'b0;
   end

   always_comb begin
      case (fmt)
         IMM_I:   imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
         IMM_J:   imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_SH:  imm = {{(XLEN-6){1'b0}}, inst[25:20]};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_22040125_idu_stage.sv
// rtl/ysyx_22040125_idu_stage.sv - decode stage: decoder plus a DEPTH-entry queue of decoded bundles
// The M-extension decode is enabled by defining YSYX_22040125_RVM_EN.
module ysyx_22040125_idu_stage
   import ysyx_22040125_config::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input logic                        clk,
   input logic                        rst,
   ysyx_22040125_idu_stage_if.slave   bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   dec_t            dec_ctl;
   logic [XLEN-1:0] dec_imm;

   ysyx_22040125_idu_dec #(.XLEN(XLEN)) u_dec (
      .inst (bus.in_inst),
      .ctl  (dec_ctl),
      .imm  (dec_imm)
   );

   dec_t            ctl_q [DEPTH];
   logic [XLEN-1:0] imm_q [DEPTH];
   logic [XLEN-1:0] pc_q  [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic            in_ready;
   logic            out_valid;
   logic            enq;
   logic            deq;
   dec_t            head;

   // Handshakes are masked during reset so nothing is seen before the counters clear
   assign in_ready  = !rst && (count != FULL_CNT);
   assign out_valid = !rst && (count != '0);
   assign enq       = bus.in_valid && in_ready && !bus.flush;
   assign deq       = out_valid && bus.out_ready && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         ctl_q[wr_ptr] <= dec_ctl;
         imm_q[wr_ptr] <= dec_imm;
         pc_q[wr_ptr]  <= bus.in_pc;
      end
   end

   assign head = out_valid ? ctl_q[rd_ptr] : '0;

   assign bus.in_ready         = in_ready;
   assign bus.out_valid        = out_valid;
   assign bus.out_pc           = out_valid ? pc_q[rd_ptr]  : '0;
   assign bus.out_imm          = out_valid ? imm_q[rd_ptr] : '0;
   assign bus.out_op           = head.op;
   assign bus.out_rd           = head.rd;
   assign bus.out_rs1          = head.rs1;
   assign bus.out_rs2          = head.rs2;
   assign bus.out_pc_sel       = head.pc_sel;
   assign bus.out_src1_sel     = head.src1_sel;
   assign bus.out_src2_sel     = head.src2_sel;
   assign bus.out_mem_size     = head.mem_size;
   assign bus.out_mem_unsigned = head.mem_unsigned;
   assign bus.out_data_wen     = head.data_wen;
   assign bus.out_data_ren     = head.data_ren;
   assign bus.out_reg_wen      = head.reg_wen;
   assign bus.out_word_op      = head.word_op;
   assign bus.out_ebreak       = head.ebreak;
   assign bus.out_illegal      = head.illegal;

endmodule

// File: tb/tb_ysyx_22040125_idu_stage.sv
// tb/tb_ysyx_22040125_idu_stage.sv - table-driven scoreboard bench for the IDU stage
module tb_ysyx_22040125_idu_stage;
   import ysyx_22040125_config::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] inst;
      logic [11:0] op;
      logic [63:0] imm;
      logic [2:0]  pc_sel;
      logic [3:0]  src;    // {src1_sel, src2_sel}
      logic [2:0]  mem;    // {mem_unsigned, mem_size}
      logic [5:0]  flags;  // {data_wen, data_ren, reg_wen, word_op, ebreak, illegal}
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] imm;
      logic [42:0] ctl;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   exp_t sb[$];
   exp_t cur_exp;

   ysyx_22040125_idu_stage_if #(.XLEN(64)) bus ();

   ysyx_22040125_idu_stage #(.XLEN(64), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [31:0] inst, input logic [11:0] op, input logic [63:0] imm,
                               input logic [2:0] pcs, input logic [3:0] src, input logic [2:0] mem,
                               input logic [5:0] flags);
      vec_t v;
      v.inst = inst; v.op = op; v.imm = imm; v.pc_sel = pcs; v.src = src; v.mem = mem; v.flags = flags;
      tbl.push_back(v);
   endfunction

   function automatic exp_t mk(input vec_t v, input logic [63:0] pc);
      exp_t e;
      logic [4:0] rs1;
      rs1   = v.flags[1] ? 5'd10 : v.inst[19:15];
      e.pc  = pc;
      e.imm = v.imm;
      e.ctl = {v.op, v.inst[11:7], rs1, v.inst[24:20], v.pc_sel, v.src, v.mem, v.flags};
      return e;
   endfunction

   logic [42:0] act_ctl;
   assign act_ctl = {bus.out_op, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_pc_sel,
                     bus.out_src1_sel, bus.out_src2_sel, bus.out_mem_unsigned, bus.out_mem_size,
                     bus.out_data_wen, bus.out_data_ren, bus.out_reg_wen, bus.out_word_op,
                     bus.out_ebreak, bus.out_illegal};

   // Scoreboard: compare the head against the oldest expected entry, then account for this cycle's transfers
   always @(negedge clk) begin
      if (rst) begin
         check("rst_out_valid", 192'(bus.out_valid), 192'(0));
         check("rst_in_ready", 192'(bus.in_ready), 192'(0));
         sb.delete();
      end else begin
         check("out_valid", 192'(bus.out_valid), 192'(sb.size() != 0));
         check("in_ready", 192'(bus.in_ready), 192'(sb.size() < DEPTH));
         if (bus.out_valid && sb.size() != 0) begin
            check("payload", {21'd0, bus.out_pc, bus.out_imm, act_ctl}, {21'd0, sb[0].pc, sb[0].imm, sb[0].ctl});
            if (bus.out_ready) void'(sb.pop_front());
         end else if (!bus.out_valid) begin
            check("empty_payload", {21'd0, bus.out_pc, bus.out_imm, act_ctl}, 192'(0));
         end
         if (bus.flush) sb.delete();
         else if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      end
   end

   task automatic drive(input int idx, input logic [63:0] pc);
      bus.in_valid = 1'b1;
      bus.in_inst  = tbl[idx].inst;
      bus.in_pc    = pc;
      cur_exp      = mk(tbl[idx], pc);
   endtask

   task automatic push(input int idx, input logic [63:0] pc);
      int n = 0;
      drive(idx, pc);
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready stayed 0, required 1 within 50 cycles");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      add(32'hfff00093, OP_ADD,   64'hffff_ffff_ffff_ffff, 3'b001, 4'b1001, 3'b000, 6'b001000);
      add(32'h002081b3, OP_ADD,   64'h0,                   3'b001, 4'b1010, 3'b000, 6'b001000);
      add(32'h407302b3, OP_SUB,   64'h0,                   3'b001, 4'b1010, 3'b000, 6'b001000);
      add(32'h12345537, OP_LUI,   64'h0000_0000_1234_5000, 3'b001, 4'b1001, 3'b000, 6'b001000);
      add(32'h800000b7, OP_LUI,   64'hffff_ffff_8000_0000, 3'b001, 4'b1001, 3'b000, 6'b001000);
      add(32'h00001117, OP_AUIPC, 64'h1000,                3'b001, 4'b0101, 3'b000, 6'b001000);
      add(32'hffdff0ef, OP_JAL,   64'hffff_ffff_ffff_fffc, 3'b010, 4'b0101, 3'b000, 6'b001000);
      add(32'h00008067, OP_JALR,  64'h0,                   3'b100, 4'b1001, 3'b000, 6'b000000);
      add(32'h00208463, OP_BEQ,   64'h8,                   3'b011, 4'b0110, 3'b000, 6'b000000);
      add(32'hfe209ce3, OP_BNE,   64'hffff_ffff_ffff_fff8, 3'b011, 4'b0110, 3'b000, 6'b000000);
      add(32'h01013283, OP_LD,    64'h10,                  3'b001, 4'b1001, 3'b011, 6'b011000);
      add(32'hfff1c303, OP_LBU,   64'hffff_ffff_ffff_ffff, 3'b001, 4'b1001, 3'b100, 6'b011000);
      add(32'h00722423, OP_SW,    64'h8,                   3'b001, 4'b1001, 3'b010, 6'b100000);
      add(32'hfe113823, OP_SD,    64'hffff_ffff_ffff_fff0, 3'b001, 4'b1001, 3'b011, 6'b100000);
      add(32'h03f09093, OP_SLL,   64'd63,                  3'b001, 4'b1001, 3'b000, 6'b001000);
      add(32'h40515113, OP_SRA,   64'd5,                   3'b001, 4'b1001, 3'b000, 6'b001000);
      add(32'h0010809b, OP_ADDW,  64'd1,                   3'b001, 4'b1001, 3'b000, 6'b001100);
      add(32'h402081bb, OP_SUBW,  64'h0,                   3'b001, 4'b1010, 3'b000, 6'b001100);
      add(32'h0ff0000f, OP_FENCE, 64'hff,                  3'b001, 4'b1001, 3'b000, 6'b000000);
      add(32'h00000073, OP_ECALL, 64'h0,                   3'b001, 4'b1001, 3'b000, 6'b000000);
      add(32'h00100073, OP_EBREAK, 64'h1,                  3'b001, 4'b1001, 3'b000, 6'b000010);
      add(32'hffffffff, OP_NONE,  64'h0,                   3'b001, 4'b1010, 3'b000, 6'b000001);
      add(32'h04009093, OP_NONE,  64'h0,                   3'b001, 4'b1010, 3'b000, 6'b000001);
      add(32'h30029073, OP_NONE,  64'h0,                   3'b001, 4'b1010, 3'b000, 6'b000001);
`ifdef YSYX_22040125_RVM_EN
      add(32'h022081b3, OP_MUL,   64'h0,                   3'b001, 4'b1010, 3'b000, 6'b001000);
`else
      add(32'h022081b3, OP_NONE,  64'h0,                   3'b001, 4'b1010, 3'b000, 6'b000001);
`endif

      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      cur_exp       = mk(tbl[0], 64'h0);
      rst           = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(1);

      // Back-to-back stream through the whole table
      for (int i = 0; i < tbl.size(); i++) push(i, 64'h8000_0000 + 64'(4 * i));
      idle(3);

      // Fill with the sink stalled, offer one more word, then release a single slot
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) push(i + 4, 64'h9000_0000 + 64'(4 * i));
      drive(1, 64'h9000_1000);
      idle(3);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      idle(1);
      bus.out_ready = 1'b0;
      idle(2);

      // Flush while full with a new word offered, then flush with space available
      push(20, 64'ha000_0000);
      drive(21, 64'ha000_0004);
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      idle(1);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      idle(2);
      bus.out_ready = 1'b0;
      push(2, 64'ha000_0100);
      drive(3, 64'ha000_0104);
      bus.flush = 1'b1;
      idle(1);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      idle(2);

      // Reset while entries are queued and a word is being offered
      push(6, 64'hb000_0000);
      push(7, 64'hb000_0004);
      drive(8, 64'hb000_0008);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      idle(2);

      // Random traffic with occasional flushes exercises pointer wrap
      for (int c = 0; c < 400; c++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.flush     = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 2) != 0) drive($urandom_range(0, tbl.size() - 1), {$urandom, $urandom});
         else bus.in_valid = 1'b0;
         idle(1);
      end
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      idle(DEPTH + 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
